// File: rtl/i2c_pkg.sv
// i2c_pkg -- shared constants for the I2C register controller.
//   CMD_*  : one-hot byte-command flags to the bit engine; a byte command
//            is the OR of its flags.
//   ST_*   : controller FSM state encodings.
//   last_idx() : index of the final byte of a transaction.
package i2c_pkg;

    localparam logic [5:0] CMD_WR   = 6'b000001;
    localparam logic [5:0] CMD_STA  = 6'b000010;
    localparam logic [5:0] CMD_RD   = 6'b000100;
    localparam logic [5:0] CMD_STO  = 6'b001000;
    localparam logic [5:0] CMD_ACK  = 6'b010000;
    localparam logic [5:0] CMD_NACK = 6'b100000;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ISSUE  = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_FINISH = 2'd3;

    localparam logic [2:0] IDX_MAX = 3'd4;

    // write/8-bit: 3 bytes, write/16-bit and read/8-bit: 4, read/16-bit: 5
    function automatic logic [2:0] last_idx(input logic is_rd, input logic addr_mode);
        return 3'd2 + {2'b00, is_rd} + {2'b00, addr_mode};
    endfunction

endpackage

// File: rtl/i2c_byte_seq.sv
// i2c_byte_seq -- combinational byte-list lookup.
//   idx       : byte index within the transaction (0..4)
//   is_rd     : 1 = register read transaction
//   addr_mode : 1 = two address bytes, 0 = low address byte only
//   dev_id    : slave address in [7:1]
//   addr      : register address
//   wrdata    : write data
//   cmd, tx   : byte command and transmit byte for this index
module i2c_byte_seq
    import i2c_pkg::*;
(
    input  logic [2:0]  idx,
    input  logic        is_rd,
    input  logic        addr_mode,
    input  logic [7:0]  dev_id,
    input  logic [15:0] addr,
    input  logic [7:0]  wrdata,
    output logic [5:0]  cmd,
    output logic [7:0]  tx
);

    logic [2:0] step;

    // In 8-bit address mode the high-address slot is skipped, so every
    // index past the first is shifted up by one into the full list.
    always_comb begin
        step = idx + {2'b00, (~addr_mode && idx != 3'd0)};
    end

    always_comb begin
        cmd = 6'b0;
        tx  = 8'h00;
        case (step)
            3'd0: begin cmd = CMD_STA | CMD_WR; tx = dev_id & 8'hFE; end
            3'd1: begin cmd = CMD_WR;           tx = addr[15:8];     end
            3'd2: begin
                cmd = is_rd ? (CMD_WR | CMD_STO) : CMD_WR;
                tx  = addr[7:0];
            end
            3'd3: begin
                if (is_rd) begin
                    cmd = CMD_STA | CMD_WR;
                    tx  = (dev_id & 8'hFE) | 8'h01;
                end else begin
                    cmd = CMD_WR | CMD_STO;
                    tx  = wrdata;
                end
            end
            3'd4: begin cmd = CMD_RD | CMD_NACK | CMD_STO; tx = 8'h00; end
            default: begin cmd = 6'b0; tx = 8'h00; end
        endcase
    end

endmodule

// File: rtl/i2c_reg_ctrl.sv
// i2c_reg_ctrl -- register read/write sequencer driving a byte-level I2C
// bit engine.
//   Clk, Rst              : clock, synchronous active-high reset
//   wrreg_req, rdreg_req  : one-cycle requests (write wins on a tie)
//   device_id, addr, addr_mode, wrdata : transaction parameters
//   rddata, RW_Done, ack, busy         : results / status
//   Cmd, Go, Tx_DATA      : byte command to the bit engine
//   Trans_Done, ack_o, Rx_DATA         : byte completion from the bit engine
module i2c_reg_ctrl
    import i2c_pkg::*;
(
    input  logic        Clk,
    input  logic        Rst,
    input  logic        wrreg_req,
    input  logic        rdreg_req,
    input  logic [7:0]  device_id,
    input  logic [15:0] addr,
    input  logic        addr_mode,
    input  logic [7:0]  wrdata,
    output logic [7:0]  rddata,
    output logic        RW_Done,
    output logic        ack,
    output logic        busy,
    output logic [5:0]  Cmd,
    output logic        Go,
    output logic [7:0]  Tx_DATA,
    input  logic        Trans_Done,
    input  logic        ack_o,
    input  logic [7:0]  Rx_DATA
);

    logic [1:0]  state;
    logic [2:0]  idx;
    logic        is_rd_q;
    logic        mode_q;
    logic [7:0]  id_q;
    logic [15:0] addr_q;
    logic [7:0]  wd_q;
    logic        ack_q;
    logic [7:0]  rddata_q;

    logic [5:0]  seq_cmd;
    logic [7:0]  seq_tx;
    logic        active;
    logic        last_byte;

    i2c_byte_seq u_seq (
        .idx       (idx),
        .is_rd     (is_rd_q),
        .addr_mode (mode_q),
        .dev_id    (id_q),
        .addr      (addr_q),
        .wrdata    (wd_q),
        .cmd       (seq_cmd),
        .tx        (seq_tx)
    );

    always_comb begin
        last_byte = (idx == last_idx(is_rd_q, mode_q)) || (idx == IDX_MAX);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= ST_IDLE;
            idx      <= 3'd0;
            is_rd_q  <= 1'b0;
            mode_q   <= 1'b0;
            id_q     <= 8'h00;
            addr_q   <= 16'h0000;
            wd_q     <= 8'h00;
            ack_q    <= 1'b0;
            rddata_q <= 8'h00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (wrreg_req || rdreg_req) begin
                        is_rd_q <= ~wrreg_req;
                        mode_q  <= addr_mode;
                        id_q    <= device_id;
                        addr_q  <= addr;
                        wd_q    <= wrdata;
                        idx     <= 3'd0;
                        ack_q   <= 1'b0;
                        state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: state <= ST_WAIT;
                ST_WAIT: begin
                    if (Trans_Done) begin
                        // only bytes we drove carry a meaningful ACK bit
                        if (|(seq_cmd & CMD_WR)) ack_q <= ack_q | ack_o;
                        if (|(seq_cmd & CMD_RD)) rddata_q <= Rx_DATA;
                        if (last_byte) begin
                            state <= ST_FINISH;
                        end else begin
                            idx   <= idx + 3'd1;
                            state <= ST_ISSUE;
                        end
                    end
                end
                ST_FINISH: begin
                    idx   <= 3'd0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Byte outputs are decoded from registered state, so they are stable
    // from Go until the matching Trans_Done advances idx.
    always_comb begin
        active  = (state == ST_ISSUE) || (state == ST_WAIT);
        busy    = active;
        Go      = (state == ST_ISSUE);
        RW_Done = (state == ST_FINISH);
        Cmd     = active ? seq_cmd : 6'b0;
        Tx_DATA = active ? seq_tx  : 8'h00;
        ack     = ack_q;
        rddata  = rddata_q;
    end

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
module tb_i2c_reg_ctrl;

    localparam logic [5:0] F_WR = 6'b000001, F_STA = 6'b000010, F_RD = 6'b000100,
                           F_STO = 6'b001000, F_NACK = 6'b100000;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        wrreg_req = 1'b0, rdreg_req = 1'b0;
    logic [7:0]  device_id = 8'h00;
    logic [15:0] addr = 16'h0000;
    logic        addr_mode = 1'b0;
    logic [7:0]  wrdata = 8'h00;
    logic [7:0]  rddata;
    logic        RW_Done, ack, busy, Go;
    logic [5:0]  Cmd;
    logic [7:0]  Tx_DATA;
    logic        Trans_Done = 1'b0;
    logic        ack_o = 1'b0;
    logic [7:0]  Rx_DATA = 8'h00;

    i2c_reg_ctrl dut (
        .Clk(Clk), .Rst(Rst), .wrreg_req(wrreg_req), .rdreg_req(rdreg_req),
        .device_id(device_id), .addr(addr), .addr_mode(addr_mode), .wrdata(wrdata),
        .rddata(rddata), .RW_Done(RW_Done), .ack(ack), .busy(busy),
        .Cmd(Cmd), .Go(Go), .Tx_DATA(Tx_DATA),
        .Trans_Done(Trans_Done), .ack_o(ack_o), .Rx_DATA(Rx_DATA)
    );

    always #10 Clk = ~Clk;

    typedef struct { logic [5:0] cmd; logic [7:0] tx; bit chk_tx; } byte_t;
    typedef struct { logic ack; logic [7:0] rd; } done_t;

    byte_t exp_b[$];
    done_t exp_d[$];
    int checks = 0, errors = 0;
    int done_cnt = 0;
    int e_go = 0;
    int txn_base = 0;
    logic [7:0] nack_mask = 8'h00;
    logic [7:0] rx_val = 8'h00;
    logic [7:0] model_rd = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    // bit-engine model: Trans_Done about 20 cycles after Go; ACK bit per byte
    // position from nack_mask, Rx_DATA from rx_val
    int  e_cnt = 0;
    bit  e_pend = 1'b0;
    int  e_idx = 0;
    always @(posedge Clk) begin
        Trans_Done <= 1'b0;
        if (Rst) begin
            e_pend <= 1'b0;
            e_cnt  <= 0;
        end else if (Go && !e_pend) begin
            e_pend <= 1'b1;
            e_cnt  <= 19;
            e_idx  <= e_go - txn_base;
            e_go   <= e_go + 1;
        end else if (e_pend) begin
            if (e_cnt == 0) begin
                Trans_Done <= 1'b1;
                e_pend     <= 1'b0;
                ack_o      <= nack_mask[e_idx[2:0]];
                Rx_DATA    <= rx_val;
            end else begin
                e_cnt <= e_cnt - 1;
            end
        end
    end

    // reference: byte list and final result computed from the protocol rules
    task automatic model_push(input bit rd, input logic [7:0] id, input logic [15:0] a,
                              input bit m, input logic [7:0] wd);
        byte_t l[$];
        done_t d;
        l.push_back('{F_STA | F_WR, {id[7:1], 1'b0}, 1'b1});
        if (m) l.push_back('{F_WR, a[15:8], 1'b1});
        if (!rd) begin
            l.push_back('{F_WR, a[7:0], 1'b1});
            l.push_back('{F_WR | F_STO, wd, 1'b1});
        end else begin
            l.push_back('{F_WR | F_STO, a[7:0], 1'b1});
            l.push_back('{F_STA | F_WR, {id[7:1], 1'b1}, 1'b1});
            l.push_back('{F_RD | F_NACK | F_STO, 8'h00, 1'b0});
        end
        d.ack = 1'b0;
        foreach (l[i]) begin
            if (l[i].cmd[0]) d.ack = d.ack | nack_mask[i];
            exp_b.push_back(l[i]);
        end
        if (rd) model_rd = rx_val;
        d.rd = model_rd;
        exp_d.push_back(d);
    endtask

    // monitor / scoreboard
    initial begin
        byte_t b;
        done_t d;
        bit prev_go;
        logic [5:0] held_cmd;
        logic [7:0] held_tx;
        prev_go = 1'b0;
        held_cmd = 6'b0;
        held_tx = 8'h00;
        forever begin
            @(negedge Clk);
            if (!Rst) begin
                if (Go) begin
                    chk("go_one_cycle", {31'b0, prev_go}, 0);
                    chk("busy_at_go", {31'b0, busy}, 1);
                    if (exp_b.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_go cmd %0h tx %0h", Cmd, Tx_DATA);
                    end else begin
                        b = exp_b.pop_front();
                        chk("cmd", {26'b0, Cmd}, {26'b0, b.cmd});
                        if (b.chk_tx) chk("tx_data", {24'b0, Tx_DATA}, {24'b0, b.tx});
                    end
                    held_cmd = Cmd;
                    held_tx  = Tx_DATA;
                end
                if (Trans_Done && busy) begin
                    chk("cmd_hold", {26'b0, Cmd}, {26'b0, held_cmd});
                    chk("tx_hold", {24'b0, Tx_DATA}, {24'b0, held_tx});
                end
                if (RW_Done) begin
                    done_cnt++;
                    if (exp_d.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_rw_done ack %0b rddata %0h", ack, rddata);
                    end else begin
                        d = exp_d.pop_front();
                        chk("ack", {31'b0, ack}, {31'b0, d.ack});
                        chk("rddata", {24'b0, rddata}, {24'b0, d.rd});
                        chk("busy_at_done", {31'b0, busy}, 0);
                    end
                end
            end
            prev_go = Go;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((busy || RW_Done) && n < 500) begin @(posedge Clk); n++; end
        if (n >= 500) chk("idle_timeout", 1, 0);
    endtask

    task automatic wait_done(input int start);
        int n = 0;
        while (done_cnt == start && n < 1000) begin @(posedge Clk); n++; end
        chk("rw_done_count", done_cnt - start, 1);
    endtask

    task automatic scramble();
        device_id = 8'($urandom);
        addr      = 16'($urandom);
        addr_mode = ~addr_mode;
        wrdata    = 8'($urandom);
    endtask

    task automatic req(input bit wr, input bit rd, input logic [7:0] id, input logic [15:0] a,
                       input bit m, input logic [7:0] wd, input bit do_wait);
        int start;
        wait_idle();
        @(posedge Clk); #1;
        start = done_cnt;
        txn_base = e_go;
        model_push(!wr, id, a, m, wd);
        device_id = id; addr = a; addr_mode = m; wrdata = wd;
        wrreg_req = wr; rdreg_req = rd;
        @(posedge Clk); #1;
        wrreg_req = 1'b0; rdreg_req = 1'b0;
        scramble();
        @(negedge Clk);
        chk("busy_after_accept", {31'b0, busy}, 1);
        chk("go_after_accept", {31'b0, Go}, 1);
        if (do_wait) wait_done(start);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        int n;
        // reset state
        repeat (3) @(posedge Clk);
        #1 Rst = 1'b0;
        @(negedge Clk);
        chk("rst_go", {31'b0, Go}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_cmd", {26'b0, Cmd}, 0);
        chk("rst_tx", {24'b0, Tx_DATA}, 0);
        chk("rst_rw_done", {31'b0, RW_Done}, 0);
        chk("rst_ack", {31'b0, ack}, 0);
        chk("rst_rddata", {24'b0, rddata}, 0);

        // directed: write, 8-bit address
        nack_mask = 8'h00; rx_val = 8'hC3;
        req(1, 0, 8'h42, 16'h0012, 0, 8'h80, 1);

        // directed: read, 16-bit address
        nack_mask = 8'h00; rx_val = 8'h5A;
        req(0, 1, 8'h42, 16'h3008, 1, 8'h00, 1);

        // NACK on the address byte: all bytes still issued, ack=1
        nack_mask = 8'h02; rx_val = 8'h77;
        req(0, 1, 8'h42, 16'h00A5, 0, 8'h00, 1);

        // write priority on a tie, plus requests while busy are dropped
        nack_mask = 8'h00; rx_val = 8'h11;
        start = done_cnt;
        req(1, 1, 8'h50, 16'h1234, 1, 8'h9C, 0);
        repeat (30) @(posedge Clk);
        #1 rdreg_req = 1'b1; wrreg_req = 1'b1; scramble();
        @(posedge Clk); #1 rdreg_req = 1'b0; wrreg_req = 1'b0;
        repeat (20) @(posedge Clk);
        #1 rdreg_req = 1'b1;
        @(posedge Clk); #1 rdreg_req = 1'b0;
        wait_done(start);
        repeat (60) @(posedge Clk);
        chk("busy_req_ignored", done_cnt - start, 1);

        // reset during byte 2 of a write
        nack_mask = 8'h00; rx_val = 8'h22;
        start = done_cnt;
        req(1, 0, 8'h6E, 16'hBEEF, 1, 8'h3D, 0);
        n = 0;
        while ((e_go - txn_base) < 2 && n < 200) begin @(posedge Clk); n++; end
        chk("second_go_seen", {31'b0, ((e_go - txn_base) >= 2)}, 1);
        repeat (5) @(posedge Clk);
        #1 Rst = 1'b1;
        @(posedge Clk); #1 Rst = 1'b0;
        exp_b.delete();
        exp_d.delete();
        model_rd = 8'h00;
        @(negedge Clk);
        chk("mid_rst_busy", {31'b0, busy}, 0);
        chk("mid_rst_go", {31'b0, Go}, 0);
        chk("mid_rst_cmd", {26'b0, Cmd}, 0);
        chk("mid_rst_tx", {24'b0, Tx_DATA}, 0);
        chk("mid_rst_ack", {31'b0, ack}, 0);
        chk("mid_rst_rddata", {24'b0, rddata}, 0);
        repeat (60) @(posedge Clk);
        chk("mid_rst_no_rw_done", done_cnt - start, 0);
        req(1, 0, 8'h6E, 16'h0044, 0, 8'hA1, 1);

        // randomized transactions
        for (int t = 0; t < 20; t++) begin
            bit rd, m;
            rd = 1'($urandom);
            m  = 1'($urandom);
            nack_mask = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            rx_val = 8'($urandom);
            req(!rd, rd, 8'($urandom), 16'($urandom), m, 8'($urandom), 1);
        end

        repeat (5) @(posedge Clk);
        chk("queues_drained", exp_b.size() + exp_d.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
